// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: drives an external 16-bit adder one chunk per cycle
// (LSB chunk first), chaining the carry, to add two WIDTH-bit operands.
// Request and result both use valid/ready handshakes.
// Optional macro WIDE_ADD_SUB_EN adds an in_sub port for A - B.
`timescale 1ns/1ps
module wide_add_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cin,
  input  logic [15:0]      add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / 16;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject widths the chunking scheme cannot handle.
  generate
    if ((WIDTH % 16) != 0 || WIDTH < 32) begin : g_width_chk
      $error("wide_add_sequencer: WIDTH must be a multiple of 16 and >= 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cin_q, cin_d, carry_q, carry_d;
  logic [IW+3:0]    off;

  // Bit offset of the current chunk.
  assign off = {idx_q, 4'b0000};

  // Adder operands: only the active chunk during RUN, zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[off +: 16];
      add_b   = b_q[off +: 16];
      add_cin = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  // Next-state: accept in IDLE, capture one chunk per RUN cycle, retire in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
`ifdef WIDE_ADD_SUB_EN
          // Subtract as A + ~B + 1; in_cin is ignored when subtracting.
          b_d     = in_sub ? ~in_b : in_b;
          cin_d   = in_sub | in_cin;
`else
          b_d     = in_b;
          cin_d   = in_cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[off +: 16] = add_sum;
        carry_d          = add_cout;
        if (idx_q == IW'(NCHUNK - 1)) state_d = DONE;
        else                          idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_zero  = ~|sum_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: behavioural 16-bit adder, directed vector
// table, backpressure and mid-operation reset sequences, random regression
// with a scoreboard queue.
`timescale 1ns/1ps
module tb_wide_add_sequencer;
  localparam int W  = 64;
  localparam int NC = W / 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout, out_zero;
  logic [W-1:0] out_sum;

  wide_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // External 16-bit adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  typedef struct { logic [W-1:0] sum; logic cout; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic cin; logic sub;
                   logic [W-1:0] esum; logic ecout; } vec_t;

  exp_t         sb[$];
  vec_t         vecs[$];
  int           n_chk = 0, n_pass = 0;
  logic         cin_trace [0:19];
  logic [W-1:0] got_sum;
  logic         got_cout;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   r;
    logic [W-1:0] bb;
    exp_t         e;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    return e;
  endfunction

  // One full transaction: accept, check latency, optional stall, retire.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int stall, input bit rnd, input bit bp);
    int   n, lat;
    bit   done, bad;
    exp_t m, e;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    m = model(a, b, cin, sub);
    sb.push_back(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    chk("busy_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      cin_trace[lat] = add_cin;
      if (rnd) out_ready = $urandom_range(0, 1) == 1;
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, NC);
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      if (out_valid !== 1'b1 || out_sum !== m.sum || in_ready !== 1'b0) bad = 1;
      in_valid = bp && (i == 5);
      in_a = '1; in_b = '1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (stall > 0) chk("stall_stable", bad, 0);
    n = 0; done = 0;
    while (!done && n < 60) begin
      out_ready = rnd ? ($urandom_range(0, 2) == 0 || n > 20) : 1'b1;
      if (out_valid && out_ready) begin
        got_sum = out_sum; got_cout = out_cout;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_sum", out_sum, e.sum);
          chk("sb_cout", out_cout, e.cout);
          chk("sb_zero", out_zero, e.sum == '0);
        end
        done = 1;
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    chk("handshake_seen", done, 1);
    chk("retire_valid", out_valid, 0);
    chk("retire_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
    rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    out_ready = 1;
    @(posedge clk); #1;
    chk("early_ready_no_effect", out_valid, 0);
    out_ready = 0;
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Directed vectors.
    vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1});
    vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b0, 64'hC, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1});
    vecs.push_back('{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                     64'h0001_0000_0001_0000, 1'b0});
`ifdef WIDE_ADD_SUB_EN
    vecs.push_back('{64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1});
    vecs.push_back('{64'd3, 64'd10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0});
`endif
    foreach (vecs[i]) begin
      run_req(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, 0, 0);
      chk($sformatf("vec%0d_sum", i), got_sum, vecs[i].esum);
      chk($sformatf("vec%0d_cout", i), got_cout, vecs[i].ecout);
      if (i == 0) begin
        chk("v0_cin_chunk0", cin_trace[0], 0);
        chk("v0_cin_chunk1", cin_trace[1], 1);
      end
      if (i == 1) chk("v1_ripple", {cin_trace[0], cin_trace[1], cin_trace[2], cin_trace[3]}, 4'hF);
    end

    // Backpressure: 10 stalled cycles with a stray in_valid pulse.
    run_req(64'd5, 64'd7, 1'b0, 1'b0, 10, 0, 1);
    chk("bp_sum", got_sum, 64'd12);

    // Reset during the 2nd RUN cycle.
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1; in_cin = 0; in_sub = 0; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1;
    chk("mid_add_a_chunk1", add_a, 16'h9ABC);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    run_req(64'd3, 64'd4, 1'b0, 1'b0, 0, 0, 0);
    chk("post_rst_sum", got_sum, 64'd7);

    // Random regression with random out_ready stalls.
    for (int k = 0; k < 1500; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 7 == 0) ra = '1;
      run_req(ra, rb, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3), 1, 0);
    end
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
